remote_link_arbiter: RTL
========================

// Module: remote_link_arbiter
// PURPOSE
//  Shares the single request/ack link to the remote fan/music board among three requesters:
//  fan speed (keypad FSM), song select and play/pause.
//  Detects value changes, arbitrates round-robin and frames one 5-bit packet per transfer.
//  Runs a four-phase request/ack handshake with timeout, and periodically re-sends full state.
//  Sits between the control FSMs and the board-to-board connector in the top level.
// PARAMETERS
//  TIMEOUT_CYCLES  2_000_000  clk cycles allowed in each ack wait before abort (>=4)
//  GAP_CYCLES      16         idle clk cycles enforced after every transfer or abort (>=1)
//  REFRESH_CYCLES  40_000_000 period of forced re-send of all three sources; 0 disables
//  CNT_W           26         width of shared timeout/gap/refresh counters; must hold max param
// PORTS
//  clk          in   1  system clock
//  rst_n        in   1  asynchronous active-low reset
//  speed        in   2  fan speed level from speed FSM (requester 0)
//  song_sel     in   3  selected song index (requester 1)
//  pause        in   1  play/pause state, 1 = playing (requester 2)
//  data_ack     in   1  ack from remote board; asynchronous, synchronised internally
//  data_request out  1  handshake request, registered
//  link_data    out  5  packet {tag[1:0], payload[2:0]}; stable while data_request=1
//  busy         out  1  1 from grant until end of GAP
//  grant        out  3  one-hot source currently on the link, 0 when idle (LED debug)
//  err_timeout  out  1  one-clk pulse on each ack timeout
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; rr pointer = last-granted 2, so source 0 wins first.
//  Reset also: pending=3'b111, so full state is sent after reset; sample regs = 0; counters 0.
//  Reset mid-transfer aborts immediately; request drops asynchronously with rst_n.
//  data_ack passes through a 2-flop synchroniser (ack_s); all decisions use ack_s.
//  Change detect: each input is sampled every clk; sample != previous sample sets that source's pending bit.
//  Refresh: counter reaching REFRESH_CYCLES-1 sets all pending bits and wraps to 0.
//  Pending set beats clear in the same cycle, so a change during a grant is never lost.
//  Packet tags/payloads:
//    00 speed, payload {1'b0,speed}; 01 song, payload song_sel; 10 pause, payload {2'b00,pause}
//    Tag 11 is reserved and never sent.
//  Payload is latched at grant; it reflects the input value in the grant cycle.
//  FSM:
//   IDLE: if any pending -> grant the first pending after the last-granted (order 0,1,2,0...);
//     clear that pending bit; latch link_data; set grant, busy; -> REQ.
//   REQ: data_request=1; wait ack_s=1 -> drop request -> WAIT_LO.
//     If TIMEOUT_CYCLES elapse first: pulse err_timeout, re-set granted pending bit,
//     drop request -> WAIT_LO.
//   WAIT_LO: wait ack_s=0 -> GAP.
//     On timeout: pulse err_timeout -> GAP; the link stays usable even if ack is stuck high.
//   GAP: count GAP_CYCLES; then grant=0, busy=0, update rr pointer -> IDLE.
//  Latency: input change at edge N -> data_request=1 at edge N+3 if idle (sample, pending, grant).
//  link_data holds last packet after transfer; it changes only at a new grant.
//  Timeout counter clears on every state entry. Only one packet is in flight at a time.
// STRUCTURE
//  Shared package/header: tag constants TAG_SPEED/TAG_SONG/TAG_PAUSE.
//  Also in package: FSM state encodings (IDLE, REQ, WAIT_LO, GAP).
//  Sub-module: rr_arbiter3 (pending[2:0], last[1:0] -> one-hot grant, purely combinational).
//  Synchroniser and counters inline.
// TESTING
//  Reset, ack echoing request after 5 clk -> three packets in order 00_0xx, 01_000, 10_000.
//    No further request afterwards.
//  speed 0->2 in idle -> link_data=5'b00_010, request 3 clk later, busy until GAP end.
//  speed, song=5 and pause=1 change in the same clk -> packets speed, song, pause.
//    Then speed change during pause transfer -> speed re-sent next.
//  ack never rises, TIMEOUT_CYCLES=8 -> err_timeout pulse, request low, GAP, then retry same packet.
//  ack stuck high after one transfer -> WAIT_LO timeout pulse, FSM returns to IDLE.
//  REFRESH_CYCLES=100 with static inputs -> all three packets re-sent every 100 clk.
//  rst_n low while request high -> all outputs 0 in the same cycle; full resend after release.

Source files
------------

// File: rtl/remote_link_arbiter_pkg.sv
// Shared definitions for the remote link arbiter: packet tags, FSM states and
// the packet framing helper.
package remote_link_arbiter_pkg;

    localparam logic [1:0] TAG_SPEED = 2'b00;
    localparam logic [1:0] TAG_SONG  = 2'b01;
    localparam logic [1:0] TAG_PAUSE = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT_LO = 2'd2,
        GAP     = 2'd3
    } link_state_e;

    function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
        if (oh[2]) return 2'd2;
        if (oh[1]) return 2'd1;
        return 2'd0;
    endfunction

    // Tag 11 is reserved, so an empty select falls through to the pause packet.
    function automatic logic [4:0] frame_packet(input logic [2:0] sel,
                                                input logic [1:0] speed,
                                                input logic [2:0] song,
                                                input logic       pause);
        if (sel[0]) return {TAG_SPEED, 1'b0, speed};
        if (sel[1]) return {TAG_SONG, song};
        return {TAG_PAUSE, 2'b00, pause};
    endfunction

endpackage

// File: rtl/remote_link_arbiter_rr_arbiter3.sv
// Three-way round-robin arbiter: grants the first pending source after the
// last-granted one, in the order 0,1,2,0...
module rr_arbiter3 (
    input  logic [2:0] pending_i,
    input  logic [1:0] last_i,
    output logic [2:0] grant_o
);

    always_comb begin
        grant_o = '0;
        case (last_i)
            2'd0: begin
                if      (pending_i[1]) grant_o = 3'b010;
                else if (pending_i[2]) grant_o = 3'b100;
                else if (pending_i[0]) grant_o = 3'b001;
            end
            2'd1: begin
                if      (pending_i[2]) grant_o = 3'b100;
                else if (pending_i[0]) grant_o = 3'b001;
                else if (pending_i[1]) grant_o = 3'b010;
            end
            default: begin
                if      (pending_i[0]) grant_o = 3'b001;
                else if (pending_i[1]) grant_o = 3'b010;
                else if (pending_i[2]) grant_o = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/remote_link_arbiter.sv
// Shares the request/ack link to the remote fan/music board among speed, song
// and play/pause sources: change detection, round-robin, four-phase handshake.
module remote_link_arbiter
    import remote_link_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
    parameter int unsigned GAP_CYCLES     = 16,
    parameter int unsigned REFRESH_CYCLES = 40_000_000,
    parameter int unsigned CNT_W          = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] speed,
    input  logic [2:0] song_sel,
    input  logic       pause,
    input  logic       data_ack,
    output logic       data_request,
    output logic [4:0] link_data,
    output logic       busy,
    output logic [2:0] grant,
    output logic       err_timeout
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(REFRESH_CYCLES - 1);

    link_state_e      state_q, state_d;
    logic             ack_meta_q, ack_s_q;
    logic [5:0]       sample_q, prev_q;
    logic [2:0]       pending_q, pending_d;
    logic [1:0]       last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] ref_cnt_q, ref_cnt_d;
    logic             req_q, req_d;
    logic [4:0]       data_q, data_d;
    logic             busy_q, busy_d;
    logic [2:0]       grant_q, grant_d;
    logic             err_q, err_d;

    logic [2:0] arb_grant, changed, pend_set, pend_clr;
    logic       tmo_hit, gap_done, refresh_hit, req_tmo, wait_tmo;

    rr_arbiter3 u_rr (
        .pending_i (pending_q),
        .last_i    (last_q),
        .grant_o   (arb_grant)
    );

    assign tmo_hit     = (cnt_q == TMO_LAST);
    assign gap_done    = (cnt_q == GAP_LAST);
    assign refresh_hit = (REFRESH_CYCLES != 0) && (ref_cnt_q == REF_LAST);
    assign req_tmo     = (state_q == REQ)     && !ack_s_q && tmo_hit;
    assign wait_tmo    = (state_q == WAIT_LO) &&  ack_s_q && tmo_hit;

    assign changed = {sample_q[5]   != prev_q[5],
                      sample_q[4:2] != prev_q[4:2],
                      sample_q[1:0] != prev_q[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|pending_q)          state_d = REQ;
            REQ:     if (ack_s_q || tmo_hit)  state_d = WAIT_LO;
            WAIT_LO: if (!ack_s_q || tmo_hit) state_d = GAP;
            GAP:     if (gap_done)            state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d     = (state_q == IDLE || state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
        ref_cnt_d = (REFRESH_CYCLES == 0 || refresh_hit) ? '0 : ref_cnt_q + CNT_W'(1);
        req_d     = (state_q == REQ) && (state_d == REQ);
        err_d     = req_tmo || wait_tmo;
        grant_d   = grant_q;
        busy_d    = busy_q;
        data_d    = data_q;
        last_d    = last_q;
        pend_clr  = '0;
        if (state_q == IDLE && |pending_q) begin
            grant_d  = arb_grant;
            busy_d   = 1'b1;
            data_d   = frame_packet(arb_grant, speed, song_sel, pause);
            pend_clr = arb_grant;
        end
        if (state_q == GAP && gap_done) begin
            grant_d = '0;
            busy_d  = 1'b0;
            last_d  = onehot_to_idx(grant_q);
        end
        // Sets are applied after the clear so a concurrent change is never dropped.
        pend_set  = changed | {3{refresh_hit}} | (req_tmo ? grant_q : 3'b000);
        pending_d = (pending_q & ~pend_clr) | pend_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
            sample_q   <= '0;
            prev_q     <= '0;
            pending_q  <= 3'b111;
            last_q     <= 2'd2;
            cnt_q      <= '0;
            ref_cnt_q  <= '0;
            req_q      <= 1'b0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            grant_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            ack_meta_q <= data_ack;
            ack_s_q    <= ack_meta_q;
            sample_q   <= {pause, song_sel, speed};
            prev_q     <= sample_q;
            pending_q  <= pending_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            ref_cnt_q  <= ref_cnt_d;
            req_q      <= req_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            grant_q    <= grant_d;
            err_q      <= err_d;
        end
    end

    assign data_request = req_q;
    assign link_data    = data_q;
    assign busy         = busy_q;
    assign grant        = grant_q;
    assign err_timeout  = err_q;

endmodule
